// File: rtl/logic_arb_pkg.sv
// Shared definitions for the round-robin logic-unit arbiter: opcode
// encodings, result-register state type and the bitwise evaluation function.
package logic_arb_pkg;

    localparam int OP_W    = 3;
    localparam int LOGIC_W = 32;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_NAND = 3'd1;
    localparam logic [OP_W-1:0] OP_OR   = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

    // Result register occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic               err;
        logic [LOGIC_W-1:0] data;
    } logic_res_t;

    // Reserved opcodes (6, 7) produce zero data with the error flag set.
    function automatic logic_res_t logic_eval(input logic [OP_W-1:0]    op,
                                              input logic [LOGIC_W-1:0] a,
                                              input logic [LOGIC_W-1:0] b);
        logic_res_t r;
        r.err = 1'b0;
        case (op)
            OP_AND:  r.data = a & b;
            OP_NAND: r.data = ~(a & b);
            OP_OR:   r.data = a | b;
            OP_NOR:  r.data = ~(a | b);
            OP_XOR:  r.data = a ^ b;
            OP_XNOR: r.data = ~(a ^ b);
            default: begin
                r.data = '0;
                r.err  = 1'b1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_rr_pick.sv
// Combinational round-robin picker: scans req_i starting at ptr_i, wrapping
// modulo N, and reports the first set bit as a one-hot grant plus its index.
module logic_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 2) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] pos;

    // Priority scan from the pointer; the first hit wins
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = '0;
        for (int k = 0; k < N; k++) begin
            pos = IDX_W'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[pos]) begin
                any_o        = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = pos;
            end
        end
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between N_REQ
// requesters, with a registered, ID-tagged result behind a valid/ready port.
// Optional per-requester grant counters are enabled by LOGIC_ARB_STATS_EN.
// WIDTH may be at most LOGIC_W (32); narrower operands are zero-extended.
module logic_unit_arbiter
    import logic_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = 32,
    parameter int ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    input  logic [N_REQ*OP_W-1:0]    req_op,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [ID_W-1:0]          res_id,
    output logic                     res_err
`ifdef LOGIC_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]      grant_count,
    input  logic                     stats_clr
`endif
);

    arb_state_t        state_q;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   ptr_d;
    logic [WIDTH-1:0]  res_data_q;
    logic [WIDTH-1:0]  res_data_d;
    logic [ID_W-1:0]   res_id_q;
    logic [ID_W-1:0]   res_id_d;
    logic              res_err_q;
    logic              res_err_d;

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   win_idx;
    logic              any_valid;
    logic              can_accept;
    logic              accept;

    logic [WIDTH-1:0]   win_a;
    logic [WIDTH-1:0]   win_b;
    logic [OP_W-1:0]    win_op;
    logic [LOGIC_W-1:0] a_ext;
    logic [LOGIC_W-1:0] b_ext;
    logic_res_t         eval_res;

    logic_rr_pick #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx),
        .any_o   (any_valid)
    );

    // A new operation can enter when the result slot is empty or being drained
    assign can_accept = (state_q == ST_EMPTY) | res_ready;
    assign accept     = any_valid & can_accept;
    assign req_ready  = reset ? '0 : (grant & {N_REQ{can_accept}});

    // Select the winning requester's operands and opcode
    always_comb begin
        win_a  = '0;
        win_b  = '0;
        win_op = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                win_a  = req_a[i*WIDTH +: WIDTH];
                win_b  = req_b[i*WIDTH +: WIDTH];
                win_op = req_op[i*OP_W +: OP_W];
            end
        end
    end

    // Evaluate the shared logic unit and form the next result fields
    always_comb begin
        a_ext              = '0;
        b_ext              = '0;
        a_ext[WIDTH-1:0]   = win_a;
        b_ext[WIDTH-1:0]   = win_b;
        eval_res           = logic_eval(win_op, a_ext, b_ext);
        res_data_d         = eval_res.data[WIDTH-1:0];
        res_err_d          = eval_res.err;
        res_id_d           = win_idx;
        ptr_d              = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    // Result-slot FSM: load on accept, empty on drain without a new accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            ptr_q      <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
            res_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                state_q    <= ST_FULL;
                ptr_q      <= ptr_d;
                res_data_q <= res_data_d;
                res_id_q   <= res_id_d;
                res_err_q  <= res_err_d;
            end else if (res_ready) begin
                state_q    <= ST_EMPTY;
            end
        end
    end

    assign res_valid = (state_q == ST_FULL);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_err   = res_err_q;

`ifdef LOGIC_ARB_STATS_EN
    logic [15:0] grant_cnt_q [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_stats
        // Saturating per-requester accept counter; clear has priority
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                grant_cnt_q[g] <= '0;
            end else if (stats_clr) begin
                grant_cnt_q[g] <= '0;
            end else if (accept && (win_idx == ID_W'(g)) && (grant_cnt_q[g] != 16'hFFFF)) begin
                grant_cnt_q[g] <= grant_cnt_q[g] + 16'd1;
            end
        end
        assign grant_count[g*16 +: 16] = grant_cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter (two requesters, 32-bit).
// Build with LOGIC_ARB_STATS_EN defined to also exercise the grant counters.
module tb_logic_unit_arbiter;

    localparam int N   = 2;
    localparam int W   = 32;
    localparam int IDW = 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N*3-1:0]   req_op;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_data;
    logic [IDW-1:0]   res_id;
    logic             res_err;
`ifdef LOGIC_ARB_STATS_EN
    logic [N*16-1:0]  grant_count;
    logic             stats_clr;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: result slot contents and round-robin pointer
    int          m_ptr;
    bit          m_valid;
    logic [W-1:0] m_data;
    int          m_id;
    bit          m_err;
    int          m_last_w;

    logic_unit_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_err   (res_err)
`ifdef LOGIC_ARB_STATS_EN
        ,
        .grant_count (grant_count),
        .stats_clr   (stats_clr)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_result(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            0: return a & b;
            1: return ~(a & b);
            2: return a | b;
            3: return ~(a | b);
            4: return a ^ b;
            5: return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    function automatic int ref_winner();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (((req_valid >> idx) & N'(1)) != 0) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] ref_ready();
        int w;
        w = ref_winner();
        if (reset || w < 0 || !(!m_valid || res_ready)) return '0;
        return N'(1) << w;
    endfunction

    task automatic m_reset();
        m_ptr = 0; m_valid = 0; m_data = '0; m_id = 0; m_err = 0; m_last_w = -1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input int op);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_op[i*3 +: 3] = 3'(op);
    endtask

    // Advance one clock; the model follows the transfer rules at the edge.
    task automatic step();
        int w;
        bit acc;
        int op;
        @(negedge clk);
        w   = ref_winner();
        acc = (w >= 0) && (!m_valid || res_ready);
        @(posedge clk);
        if (acc) begin
            op       = int'(req_op[w*3 +: 3]);
            m_valid  = 1;
            m_data   = ref_result(op, req_a[w*W +: W], req_b[w*W +: W]);
            m_err    = (op >= 6);
            m_id     = w;
            m_ptr    = (w + 1) % N;
            m_last_w = w;
        end else begin
            m_last_w = -1;
            if (res_ready) m_valid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '1; res_ready = 1'b1;
        set_req(0, 32'h1234_5678, 32'h0F0F_0F0F, 2);
        set_req(1, 32'hFFFF_0000, 32'h00FF_00FF, 4);
        #3;
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", res_valid); end
        n_vec++; if (res_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", res_data); end
        n_vec++; if (res_id !== 1'b0) begin n_err++; $display("FAIL reset_id got %h want 0", res_id); end
        n_vec++; if (res_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", res_err); end
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b want 00", req_ready); end
        @(posedge clk); #1;
        reset = 1'b0; req_valid = '0;
        m_reset();
    endtask

    task automatic test_or();
        req_valid = 2'b01; res_ready = 1'b1;
        set_req(0, 32'hF0F0_0000, 32'h0FF0_FFFF, 2);
        #1;
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL or_ready got %b want 01", req_ready); end
        step();
        n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL or_valid got %b want 1", res_valid); end
        n_vec++; if (res_data !== 32'hFFF0_FFFF) begin n_err++; $display("FAIL or_data got %h want fff0ffff", res_data); end
        n_vec++; if (res_id !== 1'b0) begin n_err++; $display("FAIL or_id got %h want 0", res_id); end
        n_vec++; if (res_err !== 1'b0) begin n_err++; $display("FAIL or_err got %b want 0", res_err); end
        req_valid = 2'b00;
        step();
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid got %b want 0", res_valid); end
        n_vec++; if (res_data !== 32'hFFF0_FFFF) begin n_err++; $display("FAIL drain_hold got %h want fff0ffff", res_data); end
    endtask

    logic [W-1:0] a0, b0, a1, b1;

    task automatic test_alternate();
        logic [N-1:0] er;
        logic [W-1:0] ed;
        reset = 1'b1; #2; reset = 1'b0;
        m_reset();
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        set_req(0, a0, b0, 3);
        set_req(1, a1, b1, 5);
        req_valid = 2'b11; res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            er = (k % 2 == 0) ? 2'b01 : 2'b10;
            ed = (k % 2 == 0) ? ~(a0 | b0) : ~(a1 ^ b1);
            #1;
            n_vec++; if (req_ready !== er) begin n_err++; $display("FAIL alt_ready[%0d] got %b want %b", k, req_ready, er); end
            step();
            n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL alt_valid[%0d] got %b want 1", k, res_valid); end
            n_vec++; if (res_id !== IDW'(k % 2)) begin n_err++; $display("FAIL alt_id[%0d] got %h want %0d", k, res_id, k % 2); end
            n_vec++; if (res_data !== ed) begin n_err++; $display("FAIL alt_data[%0d] got %h want %h", k, res_data, ed); end
        end
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL bp_ready[%0d] got %b want 00", k, req_ready); end
            step();
            n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d] got %b want 1", k, res_valid); end
            n_vec++; if (res_data !== ~(a1 ^ b1)) begin n_err++; $display("FAIL bp_hold[%0d] got %h want %h", k, res_data, ~(a1 ^ b1)); end
            n_vec++; if (res_id !== 1'b1) begin n_err++; $display("FAIL bp_id[%0d] got %h want 1", k, res_id); end
        end
        res_ready = 1'b1;
        #1;
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL bp_release_ready got %b want 01", req_ready); end
        step();
        n_vec++; if (res_id !== 1'b0) begin n_err++; $display("FAIL bp_release_id got %h want 0", res_id); end
        n_vec++; if (res_data !== ~(a0 | b0)) begin n_err++; $display("FAIL bp_release_data got %h want %h", res_data, ~(a0 | b0)); end
        req_valid = 2'b00;
        step();
    endtask

    task automatic test_reserved();
        req_valid = 2'b01;
        set_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6);
        step();
        n_vec++; if (res_data !== 32'h0) begin n_err++; $display("FAIL rsv6_data got %h want 0", res_data); end
        n_vec++; if (res_err !== 1'b1) begin n_err++; $display("FAIL rsv6_err got %b want 1", res_err); end
        req_valid = 2'b10;
        set_req(1, $urandom, $urandom, 7);
        step();
        n_vec++; if (res_data !== 32'h0) begin n_err++; $display("FAIL rsv7_data got %h want 0", res_data); end
        n_vec++; if (res_err !== 1'b1) begin n_err++; $display("FAIL rsv7_err got %b want 1", res_err); end
        n_vec++; if (res_id !== 1'b1) begin n_err++; $display("FAIL rsv7_id got %h want 1", res_id); end
        req_valid = 2'b00;
        step();
    endtask

    task automatic test_reset_mid();
        req_valid = 2'b01; res_ready = 1'b0;
        set_req(0, $urandom, $urandom, 0);
        set_req(1, $urandom, $urandom, 4);
        step();
        req_valid = 2'b11;
        n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL rmid_full got %b want 1", res_valid); end
        #2; reset = 1'b1;
        #1;
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b want 0", res_valid); end
        n_vec++; if (res_data !== 32'h0) begin n_err++; $display("FAIL rmid_data got %h want 0", res_data); end
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rmid_ready got %b want 00", req_ready); end
        m_reset();
        @(posedge clk); #1;
        reset = 1'b0; res_ready = 1'b1;
        #1;
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rmid_first_ready got %b want 01", req_ready); end
        step();
        n_vec++; if (res_id !== 1'b0) begin n_err++; $display("FAIL rmid_first_id got %h want 0", res_id); end
        req_valid = 2'b00;
        step();
    endtask

    task automatic test_random();
        logic [N-1:0] er;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || m_last_w == i) begin
                    req_valid[i] = ($urandom_range(2) != 0);
                    set_req(i, $urandom, $urandom, int'($urandom_range(7)));
                end
            end
            res_ready = ($urandom_range(3) != 0);
            #1;
            er = ref_ready();
            n_vec++; if (req_ready !== er) begin n_err++; $display("FAIL rnd_ready[%0d] got %b want %b", c, req_ready, er); end
            step();
            n_vec++; if (res_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid[%0d] got %b want %b", c, res_valid, m_valid); end
            n_vec++; if (res_data !== m_data) begin n_err++; $display("FAIL rnd_data[%0d] got %h want %h", c, res_data, m_data); end
            n_vec++; if (res_id !== IDW'(m_id)) begin n_err++; $display("FAIL rnd_id[%0d] got %h want %0d", c, res_id, m_id); end
            n_vec++; if (res_err !== m_err) begin n_err++; $display("FAIL rnd_err[%0d] got %b want %b", c, res_err, m_err); end
        end
        req_valid = '0;
        res_ready = 1'b1;
        step();
    endtask

`ifdef LOGIC_ARB_STATS_EN
    task automatic test_stats();
        stats_clr = 1'b1; req_valid = 2'b00;
        step();
        stats_clr = 1'b0;
        n_vec++; if (grant_count !== 32'h0) begin n_err++; $display("FAIL stats_clr0 got %h want 0", grant_count); end
        req_valid = 2'b10; res_ready = 1'b1;
        set_req(1, $urandom, $urandom, 4);
        for (int k = 0; k < 70000; k++) step();
        n_vec++; if (grant_count[31:16] !== 16'hFFFF) begin n_err++; $display("FAIL stats_sat1 got %h want ffff", grant_count[31:16]); end
        n_vec++; if (grant_count[15:0] !== 16'h0) begin n_err++; $display("FAIL stats_idle0 got %h want 0", grant_count[15:0]); end
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        n_vec++; if (grant_count !== 32'h0) begin n_err++; $display("FAIL stats_clr_wins got %h want 0", grant_count); end
        step();
        n_vec++; if (grant_count[31:16] !== 16'h1) begin n_err++; $display("FAIL stats_restart got %h want 1", grant_count[31:16]); end
        req_valid = 2'b00;
        step();
    endtask
`endif

    initial begin
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; res_ready = 1'b0;
`ifdef LOGIC_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        m_reset();
        test_reset();
        test_or();
        test_alternate();
        test_backpressure();
        test_reserved();
        test_reset_mid();
        test_random();
`ifdef LOGIC_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
